// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter and command sequencer for a single-port 1rw SRAM macro.
// Macro controls are registered; read results are routed back to their issuer via an owner-tag pipe.
module sram_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  en,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_web,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_web,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  busy
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_t;

  ptr_t ptr_q, ptr_d;

  // Stage k holds the tag of a read whose macro cycle was k cycles ago; stage RD_LAT meets dout0.
  logic [RD_LAT:0] tag_vld;
  logic [RD_LAT:0] tag_own;
  logic            rd_issue;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rstb0 && en) begin
      a_ready = a_valid && (!b_valid || (ptr_q == PTR_A));
      b_ready = b_valid && (!a_valid || (ptr_q == PTR_B));
    end
    ptr_d = ptr_q;
    if (a_ready) begin
      ptr_d = PTR_B;
    end else if (b_ready) begin
      ptr_d = PTR_A;
    end
    rd_issue = (a_ready && a_web) || (b_ready && b_web);
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      ptr_q   <= PTR_A;
      csb0    <= 1'b1;
      web0    <= 1'b1;
      addr0   <= '0;
      din0    <= '0;
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      ptr_q <= ptr_d;
      csb0  <= !(a_ready || b_ready);
      if (a_ready) begin
        web0  <= a_web;
        addr0 <= a_addr;
        din0  <= a_din;
      end else if (b_ready) begin
        web0  <= b_web;
        addr0 <= b_addr;
        din0  <= b_din;
      end else begin
        web0  <= 1'b1;
      end
      tag_vld[0] <= rd_issue;
      tag_own[0] <= b_ready;
      tag_vld[RD_LAT:1] <= tag_vld[RD_LAT-1:0];
      tag_own[RD_LAT:1] <= tag_own[RD_LAT-1:0];
    end
  end

  always_comb begin
    a_rvalid = tag_vld[RD_LAT] && !tag_own[RD_LAT];
    b_rvalid = tag_vld[RD_LAT] &&  tag_own[RD_LAT];
    a_dout   = a_rvalid ? dout0 : '0;
    b_dout   = b_rvalid ? dout0 : '0;
    busy     = |tag_vld;
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: per-cycle vector table plus hand sequences,
// with behavioural SRAM macros for RD_LAT=1 and RD_LAT=2 instances.
module tb_sram_rr_arbiter;

  localparam logic Y = 1'b1, N = 1'b0, RD = 1'b1, WR = 1'b0;

  logic        clk0 = 1'b0;
  logic        rstb0, en, init_mem;
  logic        a_valid, a_web, b_valid, b_web;
  logic [6:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic        a_ready, b_ready, a_rvalid, b_rvalid, csb0, web0, busy;
  logic [31:0] a_dout, b_dout, din0, dout0;
  logic [6:0]  addr0;

  logic        a_ready_2, b_ready_2, a_rvalid_2, b_rvalid_2, csb0_2, web0_2, busy_2;
  logic [31:0] a_dout_2, b_dout_2, din0_2, dout0_2, rd1_2;
  logic [6:0]  addr0_2;

  logic [31:0] mem1 [0:127];
  logic [31:0] mem2 [0:127];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk0 = ~clk0;

  sram_rr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RD_LAT(1)) dut (
    .clk0(clk0), .rstb0(rstb0), .en(en),
    .a_valid(a_valid), .a_ready(a_ready), .a_web(a_web), .a_addr(a_addr), .a_din(a_din),
    .a_rvalid(a_rvalid), .a_dout(a_dout),
    .b_valid(b_valid), .b_ready(b_ready), .b_web(b_web), .b_addr(b_addr), .b_din(b_din),
    .b_rvalid(b_rvalid), .b_dout(b_dout),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0), .busy(busy)
  );

  sram_rr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RD_LAT(2)) dut2 (
    .clk0(clk0), .rstb0(rstb0), .en(en),
    .a_valid(a_valid), .a_ready(a_ready_2), .a_web(a_web), .a_addr(a_addr), .a_din(a_din),
    .a_rvalid(a_rvalid_2), .a_dout(a_dout_2),
    .b_valid(b_valid), .b_ready(b_ready_2), .b_web(b_web), .b_addr(b_addr), .b_din(b_din),
    .b_rvalid(b_rvalid_2), .b_dout(b_dout_2),
    .csb0(csb0_2), .web0(web0_2), .addr0(addr0_2), .din0(din0_2), .dout0(dout0_2), .busy(busy_2)
  );

  // Macro models: contents preset to 0x10000000+addr so unwritten reads are predictable.
  always @(posedge clk0) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) mem1[i] <= 32'h1000_0000 + 32'(i);
    end else if (!csb0) begin
      if (!web0) mem1[addr0] <= din0;
      else       dout0 <= mem1[addr0];
    end
  end

  always @(posedge clk0) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) mem2[i] <= 32'h1000_0000 + 32'(i);
    end else if (!csb0_2) begin
      if (!web0_2) mem2[addr0_2] <= din0_2;
      else         rd1_2 <= mem2[addr0_2];
    end
    dout0_2 <= rd1_2;
  end

  typedef struct {
    logic rst, en, av, aw; logic [6:0] aa; logic [31:0] ad;
    logic bv, bw; logic [6:0] ba; logic [31:0] bd;
    logic ar, br, csb, web; logic [6:0] addr; logic [31:0] din;
    logic arv; logic [31:0] ado; logic brv; logic [31:0] bdo; logic busy;
    logic c2, b2rv; logic [31:0] b2do;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setin(input logic rst, input logic e,
                       input logic av, input logic aw, input logic [6:0] aa, input logic [31:0] ad,
                       input logic bv, input logic bw, input logic [6:0] ba, input logic [31:0] bd);
    @(negedge clk0);
    rstb0 = rst; en = e;
    a_valid = av; a_web = aw; a_addr = aa; a_din = ad;
    b_valid = bv; b_web = bw; b_addr = ba; b_din = bd;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    //          rst en  A:v  web addr   din            B:v  web addr   din           ar br csb web addr   din            arv a_dout        brv b_dout        busy c2 b2rv b2_dout
    tbl[0]  = '{N, Y,   Y, RD, 7'h0A, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h00, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[1]  = '{Y, Y,   Y, WR, 7'h0A, 32'hFACECAFE,   N, RD, 7'h00, 32'h0,         Y, N, Y, Y,  7'h00, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[2]  = '{Y, Y,   Y, RD, 7'h0A, 32'h0,          N, RD, 7'h00, 32'h0,         Y, N, N, WR, 7'h0A, 32'hFACECAFE,   N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[3]  = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, N, RD, 7'h0A, 32'h0,          N, 32'h0,         N, 32'h0,         Y,  N, N, 32'h0};
    tbl[4]  = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h0A, 32'h0,          Y, 32'hFACECAFE,  N, 32'h0,         Y,  N, N, 32'h0};
    tbl[5]  = '{Y, Y,   N, RD, 7'h00, 32'h0,          Y, RD, 7'h03, 32'h0,         N, Y, Y, Y,  7'h0A, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[6]  = '{Y, Y,   N, RD, 7'h00, 32'h0,          Y, RD, 7'h04, 32'h0,         N, Y, N, RD, 7'h03, 32'h0,          N, 32'h0,         N, 32'h0,         Y,  N, N, 32'h0};
    tbl[7]  = '{Y, Y,   N, RD, 7'h00, 32'h0,          Y, RD, 7'h05, 32'h0,         N, Y, N, RD, 7'h04, 32'h0,          N, 32'h0,         Y, 32'h10000003,  Y,  N, N, 32'h0};
    tbl[8]  = '{Y, Y,   Y, RD, 7'h01, 32'h0,          Y, RD, 7'h02, 32'h0,         Y, N, N, RD, 7'h05, 32'h0,          N, 32'h0,         Y, 32'h10000004,  Y,  N, N, 32'h0};
    tbl[9]  = '{Y, Y,   Y, RD, 7'h01, 32'h0,          Y, RD, 7'h02, 32'h0,         N, Y, N, RD, 7'h01, 32'h0,          N, 32'h0,         Y, 32'h10000005,  Y,  N, N, 32'h0};
    tbl[10] = '{Y, Y,   Y, RD, 7'h01, 32'h0,          Y, RD, 7'h02, 32'h0,         Y, N, N, RD, 7'h02, 32'h0,          Y, 32'h10000001,  N, 32'h0,         Y,  N, N, 32'h0};
    tbl[11] = '{Y, Y,   Y, RD, 7'h01, 32'h0,          Y, RD, 7'h02, 32'h0,         N, Y, N, RD, 7'h01, 32'h0,          N, 32'h0,         Y, 32'h10000002,  Y,  N, N, 32'h0};
    tbl[12] = '{Y, Y,   Y, RD, 7'h01, 32'h0,          N, RD, 7'h00, 32'h0,         Y, N, N, RD, 7'h02, 32'h0,          Y, 32'h10000001,  N, 32'h0,         Y,  N, N, 32'h0};
    tbl[13] = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, N, RD, 7'h01, 32'h0,          N, 32'h0,         Y, 32'h10000002,  Y,  N, N, 32'h0};
    tbl[14] = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h01, 32'h0,          Y, 32'h10000001,  N, 32'h0,         Y,  N, N, 32'h0};
    tbl[15] = '{Y, Y,   Y, RD, 7'h06, 32'h0,          N, RD, 7'h00, 32'h0,         Y, N, Y, Y,  7'h01, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[16] = '{Y, N,   Y, RD, 7'h07, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, N, RD, 7'h06, 32'h0,          N, 32'h0,         N, 32'h0,         Y,  N, N, 32'h0};
    tbl[17] = '{Y, N,   Y, RD, 7'h07, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h06, 32'h0,          Y, 32'h10000006,  N, 32'h0,         Y,  N, N, 32'h0};
    tbl[18] = '{Y, N,   Y, RD, 7'h07, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h06, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[19] = '{Y, Y,   Y, RD, 7'h07, 32'h0,          N, RD, 7'h00, 32'h0,         Y, N, Y, Y,  7'h06, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[20] = '{N, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, N, RD, 7'h07, 32'h0,          N, 32'h0,         N, 32'h0,         Y,  N, N, 32'h0};
    tbl[21] = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h00, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[22] = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h00, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[23] = '{Y, Y,   Y, WR, 7'h7F, 32'hDEADBEEF,   Y, RD, 7'h7F, 32'h0,         Y, N, Y, Y,  7'h00, 32'h0,          N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[24] = '{Y, Y,   N, RD, 7'h00, 32'h0,          Y, RD, 7'h7F, 32'h0,         N, Y, N, WR, 7'h7F, 32'hDEADBEEF,   N, 32'h0,         N, 32'h0,         N,  N, N, 32'h0};
    tbl[25] = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, N, RD, 7'h7F, 32'h0,          N, 32'h0,         N, 32'h0,         Y,  Y, N, 32'h0};
    tbl[26] = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h7F, 32'h0,          N, 32'h0,         Y, 32'hDEADBEEF,  Y,  Y, N, 32'h0};
    tbl[27] = '{Y, Y,   N, RD, 7'h00, 32'h0,          N, RD, 7'h00, 32'h0,         N, N, Y, Y,  7'h7F, 32'h0,          N, 32'h0,         N, 32'h0,         N,  Y, Y, 32'hDEADBEEF};

    rstb0 = 1'b0; en = 1'b1; init_mem = 1'b1;
    a_valid = 1'b0; a_web = 1'b1; a_addr = '0; a_din = '0;
    b_valid = 1'b0; b_web = 1'b1; b_addr = '0; b_din = '0;
    @(posedge clk0);
    #1 init_mem = 1'b0;

    for (int i = 0; i < 28; i++) begin
      setin(tbl[i].rst, tbl[i].en, tbl[i].av, tbl[i].aw, tbl[i].aa, tbl[i].ad,
            tbl[i].bv, tbl[i].bw, tbl[i].ba, tbl[i].bd);
      chk($sformatf("r%0d a_ready", i),  32'(a_ready),  32'(tbl[i].ar));
      chk($sformatf("r%0d b_ready", i),  32'(b_ready),  32'(tbl[i].br));
      chk($sformatf("r%0d csb0", i),     32'(csb0),     32'(tbl[i].csb));
      chk($sformatf("r%0d web0", i),     32'(web0),     32'(tbl[i].web));
      chk($sformatf("r%0d addr0", i),    32'(addr0),    32'(tbl[i].addr));
      chk($sformatf("r%0d din0", i),     din0,          tbl[i].din);
      chk($sformatf("r%0d a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].arv));
      chk($sformatf("r%0d a_dout", i),   a_dout,        tbl[i].ado);
      chk($sformatf("r%0d b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].brv));
      chk($sformatf("r%0d b_dout", i),   b_dout,        tbl[i].bdo);
      chk($sformatf("r%0d busy", i),     32'(busy),     32'(tbl[i].busy));
      if (tbl[i].c2) begin
        chk($sformatf("r%0d lat2 b_rvalid", i), 32'(b_rvalid_2), 32'(tbl[i].b2rv));
        chk($sformatf("r%0d lat2 b_dout", i),   b_dout_2,        tbl[i].b2do);
      end
    end

    // Pointer must hold through disabled cycles, then grant resumes at the held side.
    setin(Y, Y, Y, WR, 7'h10, 32'h11111111, N, RD, 7'h00, 32'h0);
    chk("h0 a_ready", 32'(a_ready), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      setin(Y, N, Y, WR, 7'h11, 32'h33333333, Y, WR, 7'h12, 32'h22222222);
      chk($sformatf("h%0d a_ready", k), 32'(a_ready), 32'h0);
      chk($sformatf("h%0d b_ready", k), 32'(b_ready), 32'h0);
      chk($sformatf("h%0d csb0", k),    32'(csb0),    (k == 1) ? 32'h0 : 32'h1);
    end
    setin(Y, Y, Y, WR, 7'h11, 32'h33333333, Y, WR, 7'h12, 32'h22222222);
    chk("h4 b_ready", 32'(b_ready), 32'h1);
    chk("h4 a_ready", 32'(a_ready), 32'h0);
    setin(Y, Y, Y, WR, 7'h11, 32'h33333333, N, RD, 7'h00, 32'h0);
    chk("h5 a_ready", 32'(a_ready), 32'h1);
    chk("h5 addr0",   32'(addr0),   32'h12);
    chk("h5 web0",    32'(web0),    32'h0);
    setin(Y, Y, Y, RD, 7'h12, 32'h0, N, RD, 7'h00, 32'h0);
    chk("h6 a_ready", 32'(a_ready), 32'h1);
    chk("h6 din0",    din0,         32'h33333333);
    setin(Y, Y, N, RD, 7'h00, 32'h0, Y, RD, 7'h11, 32'h0);
    chk("h7 b_ready", 32'(b_ready), 32'h1);
    setin(Y, Y, N, RD, 7'h00, 32'h0, N, RD, 7'h00, 32'h0);
    chk("h8 a_rvalid", 32'(a_rvalid), 32'h1);
    chk("h8 a_dout",   a_dout,        32'h22222222);
    chk("h8 b_rvalid", 32'(b_rvalid), 32'h0);
    setin(Y, Y, N, RD, 7'h00, 32'h0, N, RD, 7'h00, 32'h0);
    chk("h9 b_rvalid", 32'(b_rvalid), 32'h1);
    chk("h9 b_dout",   b_dout,        32'h33333333);
    chk("h9 a_rvalid", 32'(a_rvalid), 32'h0);
    setin(Y, Y, N, RD, 7'h00, 32'h0, N, RD, 7'h00, 32'h0);
    chk("h10 busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
